// File: rtl/s38584_pkg.sv
// Shared types and defaults for the s38584 event-latch bank.
// Contents: per-channel state enum, default CH/DEBOUNCE/CNT_W, index-width helper.
package s38584_pkg;

    localparam int unsigned CH_DEF       = 4;
    localparam int unsigned DEBOUNCE_DEF = 3;
    localparam int unsigned CNT_W_DEF    = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMING  = 2'd1,
        LATCHED = 2'd2,
        HOLDOFF = 2'd3
    } evt_state_t;

    // Bits needed to encode 0..n-1; never below 1 so a port is always legal.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/s38584_evt_chan.sv
// One debounced, acknowledge-cleared event flag.
// Ports:
//   CK, RN      clock (rising), async active-low reset
//   en_i        step enable; all state holds when low
//   evt_i       qualified event level
//   mask_i      1 blocks arming (no effect once latched)
//   ack_i       clears the flag when latched
//   flag_o      registered, 1 exactly while in LATCHED
module s38584_evt_chan
    import s38584_pkg::*;
#(
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic CK,
    input  logic RN,
    input  logic en_i,
    input  logic evt_i,
    input  logic mask_i,
    input  logic ack_i,
    output logic flag_o
);

    evt_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             q_c;
    logic [CNT_W:0]   cnt_inc_c;

    assign q_c       = evt_i & ~mask_i;
    // One extra bit so the compare against DEBOUNCE cannot wrap.
    assign cnt_inc_c = {1'b0, cnt_q} + (CNT_W+1)'(1);

    // Next-state and counter update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (en_i) begin
            unique case (state_q)
                IDLE: begin
                    if (q_c) begin
                        if (DEBOUNCE == 1) begin
                            state_d = LATCHED;
                        end else begin
                            state_d = ARMING;
                            cnt_d   = CNT_W'(1);
                        end
                    end
                end
                ARMING: begin
                    if (!q_c) begin
                        // Dropped or masked sample restarts the debounce.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc_c == (CNT_W+1)'(DEBOUNCE)) begin
                        state_d = LATCHED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_inc_c[CNT_W-1:0];
                    end
                end
                LATCHED: begin
                    // A still-high event after ack parks in HOLDOFF to avoid re-latching.
                    if (ack_i) begin
                        state_d = evt_i ? HOLDOFF : IDLE;
                    end
                end
                HOLDOFF: begin
                    if (!evt_i) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and flag registers.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            flag_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            flag_o  <= (state_d == LATCHED);
        end
    end

endmodule

// File: rtl/s38584_evt_latch_bank.sv
// N-channel event-latch bank with pending count and lowest-pending index.
// Ports:
//   CK, RN        clock (rising), async active-low reset
//   en_i          global step enable
//   evt_i[CH]     per-channel event level
//   mask_i[CH]    per-channel arm mask
//   ack_i[CH]     per-channel acknowledge
//   flag_o[CH]    registered latched flags
//   irq_o         OR of flags
//   pend_cnt_o    number of set flags
//   first_vld_o   any flag set
//   first_idx_o   lowest set flag index, 0 when none
module s38584_evt_latch_bank
    import s38584_pkg::*;
#(
    parameter int unsigned CH       = CH_DEF,
    parameter int unsigned DEBOUNCE = DEBOUNCE_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                      CK,
    input  logic                      RN,
    input  logic                      en_i,
    input  logic [CH-1:0]             evt_i,
    input  logic [CH-1:0]             mask_i,
    input  logic [CH-1:0]             ack_i,
    output logic [CH-1:0]             flag_o,
    output logic                      irq_o,
    output logic [idx_w(CH+1)-1:0]    pend_cnt_o,
    output logic                      first_vld_o,
    output logic [idx_w(CH)-1:0]      first_idx_o
);

    localparam int unsigned PEND_W = idx_w(CH + 1);
    localparam int unsigned IDX_W  = idx_w(CH);

    // One FSM per channel.
    for (genvar c = 0; c < int'(CH); c++) begin : g_chan
        s38584_evt_chan #(
            .DEBOUNCE (DEBOUNCE),
            .CNT_W    (CNT_W)
        ) u_chan (
            .CK     (CK),
            .RN     (RN),
            .en_i   (en_i),
            .evt_i  (evt_i[c]),
            .mask_i (mask_i[c]),
            .ack_i  (ack_i[c]),
            .flag_o (flag_o[c])
        );
    end

    assign irq_o       = |flag_o;
    assign first_vld_o = |flag_o;

    // Popcount and priority encoder; scanning downward leaves the lowest index.
    always_comb begin
        pend_cnt_o  = '0;
        first_idx_o = '0;
        for (int i = int'(CH) - 1; i >= 0; i--) begin
            if (flag_o[i]) begin
                first_idx_o = IDX_W'(i);
            end
            pend_cnt_o = pend_cnt_o + PEND_W'(flag_o[i]);
        end
    end

endmodule

// File: tb/tb_s38584_evt_latch_bank.sv
module tb_s38584_evt_latch_bank;

    logic CK = 1'b0;
    logic RN = 1'b1;
    always #5 CK = ~CK;

    // Unit 0: CH=4, DEBOUNCE=3
    logic       en0 = 1'b1;
    logic [3:0] evt0 = '0, mask0 = '0, ack0 = '0;
    logic [3:0] flag0;
    logic       irq0, vld0;
    logic [2:0] pend0;
    logic [1:0] idx0;

    // Unit 1: CH=2, DEBOUNCE=1
    logic       en1 = 1'b1;
    logic [1:0] evt1 = '0, mask1 = '0, ack1 = '0;
    logic [1:0] flag1;
    logic       irq1, vld1;
    logic [1:0] pend1;
    logic [0:0] idx1;

    // Unit 2: CH=8, DEBOUNCE=7
    logic       en2 = 1'b1;
    logic [7:0] evt2 = '0, mask2 = '0, ack2 = '0;
    logic [7:0] flag2;
    logic       irq2, vld2;
    logic [3:0] pend2;
    logic [2:0] idx2;

    s38584_evt_latch_bank #(.CH(4), .DEBOUNCE(3), .CNT_W(3)) dut0 (
        .CK(CK), .RN(RN), .en_i(en0), .evt_i(evt0), .mask_i(mask0), .ack_i(ack0),
        .flag_o(flag0), .irq_o(irq0), .pend_cnt_o(pend0), .first_vld_o(vld0), .first_idx_o(idx0));

    s38584_evt_latch_bank #(.CH(2), .DEBOUNCE(1), .CNT_W(1)) dut1 (
        .CK(CK), .RN(RN), .en_i(en1), .evt_i(evt1), .mask_i(mask1), .ack_i(ack1),
        .flag_o(flag1), .irq_o(irq1), .pend_cnt_o(pend1), .first_vld_o(vld1), .first_idx_o(idx1));

    s38584_evt_latch_bank #(.CH(8), .DEBOUNCE(7), .CNT_W(3)) dut2 (
        .CK(CK), .RN(RN), .en_i(en2), .evt_i(evt2), .mask_i(mask2), .ack_i(ack2),
        .flag_o(flag2), .irq_o(irq2), .pend_cnt_o(pend2), .first_vld_o(vld2), .first_idx_o(idx2));

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Behavioural model: run length of consecutive enabled qualified samples,
    // a latched bit and a hold-off bit per channel.
    int chs [3] = '{4, 2, 8};
    int debs[3] = '{3, 1, 7};
    int run [3][8];
    bit lat [3][8];
    bit hold[3][8];

    task automatic mstep(input int u, input logic en, input logic [7:0] ev,
                         input logic [7:0] mk, input logic [7:0] ak);
        if (!en) return;
        for (int c = 0; c < chs[u]; c++) begin
            if (lat[u][c]) begin
                if (ak[c]) begin
                    lat[u][c]  = 1'b0;
                    hold[u][c] = ev[c];
                end
            end else if (hold[u][c]) begin
                if (!ev[c]) hold[u][c] = 1'b0;
            end else if (ev[c] && !mk[c]) begin
                run[u][c]++;
                if (run[u][c] >= debs[u]) begin
                    lat[u][c] = 1'b1;
                    run[u][c] = 0;
                end
            end else begin
                run[u][c] = 0;
            end
        end
    endtask

    always @(posedge CK or negedge RN) begin
        if (!RN) begin
            for (int u = 0; u < 3; u++)
                for (int c = 0; c < 8; c++) begin
                    run[u][c] = 0; lat[u][c] = 1'b0; hold[u][c] = 1'b0;
                end
        end else begin
            mstep(0, en0, 8'(evt0), 8'(mask0), 8'(ack0));
            mstep(1, en1, 8'(evt1), 8'(mask1), 8'(ack1));
            mstep(2, en2, evt2, mask2, ack2);
        end
    end

    function automatic logic [7:0] mflags(input int u);
        logic [7:0] r = '0;
        for (int c = 0; c < 8; c++) r[c] = lat[u][c];
        return r;
    endfunction

    function automatic int low_idx(input logic [7:0] f);
        int r = 0;
        for (int i = 7; i >= 0; i--) if (f[i]) r = i;
        return r;
    endfunction

    task automatic cmp_unit(input int u, input logic [7:0] f, input logic irq,
                            input logic [3:0] pend, input logic vld, input logic [2:0] idx);
        logic [7:0] e;
        e = mflags(u);
        chk($sformatf("u%0d_flag", u), 32'(f), 32'(e));
        chk($sformatf("u%0d_irq", u), 32'(irq), 32'(|e));
        chk($sformatf("u%0d_vld", u), 32'(vld), 32'(|e));
        chk($sformatf("u%0d_pend", u), 32'(pend), 32'($countones(e)));
        chk($sformatf("u%0d_idx", u), 32'(idx), 32'(low_idx(e)));
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge CK) begin
        cmp_unit(0, 8'(flag0), irq0, 4'(pend0), vld0, 3'(idx0));
        cmp_unit(1, 8'(flag1), irq1, 4'(pend1), vld1, 3'(idx1));
        cmp_unit(2, flag2, irq2, pend2, vld2, idx2);
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CK);
            #1;
        end
    endtask

    initial begin
        #1 RN = 1'b0;
        #3;
        chk("rst_flag0", 32'(flag0), 32'h0);
        chk("rst_pend0", 32'(pend0), 32'h0);
        chk("rst_irq0",  32'(irq0),  32'h0);
        chk("rst_vld0",  32'(vld0),  32'h0);
        chk("rst_idx0",  32'(idx0),  32'h0);
        #8 RN = 1'b1;

        // Reset and latch on channel 1
        evt0 = 4'b0010;
        tick(2);
        chk("lat_early", 32'(flag0), 32'h0);
        tick(1);
        chk("lat_flag", 32'(flag0), 32'b0010);
        chk("lat_pend", 32'(pend0), 32'd1);
        chk("lat_idx",  32'(idx0),  32'd1);
        chk("lat_irq",  32'(irq0),  32'd1);
        evt0 = 4'b0000; ack0 = 4'b0010;
        tick(1);
        chk("ack_clr", 32'(flag0), 32'h0);
        ack0 = '0;

        // Debounce restart on channel 0: high 2, low 1, high 3
        evt0 = 4'b0001; tick(2);
        evt0 = 4'b0000; tick(1);
        evt0 = 4'b0001; tick(2);
        chk("restart_early", 32'(flag0), 32'h0);
        tick(1);
        chk("restart_lat", 32'(flag0), 32'b0001);
        evt0 = '0; ack0 = 4'b0001; tick(1); ack0 = '0;

        // Enable stall on channel 2: en 1,0,0,1,1
        evt0 = 4'b0100;
        en0 = 1'b1; tick(1);
        en0 = 1'b0; tick(2);
        en0 = 1'b1; tick(1);
        chk("stall_early", 32'(flag0), 32'h0);
        tick(1);
        chk("stall_lat", 32'(flag0), 32'b0100);
        evt0 = '0; ack0 = 4'b0100; tick(1); ack0 = '0;

        // Ack while event held, hold-off, then re-latch on channel 3
        evt0 = 4'b1000; tick(3);
        chk("ho_lat", 32'(flag0), 32'b1000);
        ack0 = 4'b1000; tick(1);
        chk("ho_ack", 32'(flag0), 32'h0);
        ack0 = '0; tick(3);
        chk("ho_held", 32'(flag0), 32'h0);
        evt0 = 4'b0000; tick(1);
        evt0 = 4'b1000; tick(2);
        chk("ho_relat_early", 32'(flag0), 32'h0);
        tick(1);
        chk("ho_relat", 32'(flag0), 32'b1000);
        evt0 = '0; ack0 = 4'b1000; tick(1); ack0 = '0;

        // Mask mid-arming on channel 0 restarts the count
        evt0 = 4'b0001; tick(1);
        mask0 = 4'b0001; tick(1);
        mask0 = 4'b0000; tick(2);
        chk("mask_nolat", 32'(flag0), 32'h0);
        tick(1);
        chk("mask_lat", 32'(flag0), 32'b0001);

        // All channels latched, then lowest acked
        evt0 = 4'b1111; tick(3);
        chk("all_flag", 32'(flag0), 32'hF);
        chk("all_pend", 32'(pend0), 32'd4);
        chk("all_idx",  32'(idx0),  32'd0);
        ack0 = 4'b0001; tick(1); ack0 = '0;
        chk("low_ack_flag", 32'(flag0), 32'hE);
        chk("low_ack_pend", 32'(pend0), 32'd3);
        chk("low_ack_idx",  32'(idx0),  32'd1);

        // Asynchronous reset mid-cycle
        #2 RN = 1'b0;
        #1;
        chk("arst_flag", 32'(flag0), 32'h0);
        chk("arst_pend", 32'(pend0), 32'h0);
        chk("arst_irq",  32'(irq0),  32'h0);
        chk("arst_vld",  32'(vld0),  32'h0);
        chk("arst_idx",  32'(idx0),  32'h0);
        evt0 = 4'b0001;
        #2 RN = 1'b1;
        tick(2);
        chk("arst_nomem", 32'(flag0), 32'h0);
        tick(1);
        chk("arst_relat", 32'(flag0), 32'b0001);
        evt0 = '0; ack0 = 4'b0001; tick(1); ack0 = '0;

        // CH=2, DEBOUNCE=1: one-edge latency, every single-bit pattern
        for (int c = 0; c < 2; c++) begin
            evt1 = 2'(1 << c); tick(1);
            chk($sformatf("sw1_flag%0d", c), 32'(flag1), 32'(1 << c));
            chk($sformatf("sw1_idx%0d", c),  32'(idx1),  32'(c));
            evt1 = '0; ack1 = 2'(1 << c); tick(1); ack1 = '0;
        end

        // CH=8, DEBOUNCE=7: seven-edge latency, every single-bit pattern
        for (int c = 0; c < 8; c++) begin
            evt2 = 8'(1 << c); tick(6);
            chk($sformatf("sw2_early%0d", c), 32'(flag2), 32'h0);
            tick(1);
            chk($sformatf("sw2_flag%0d", c), 32'(flag2), 32'(1 << c));
            chk($sformatf("sw2_idx%0d", c),  32'(idx2),  32'(c));
            chk($sformatf("sw2_pend%0d", c), 32'(pend2), 32'd1);
            evt2 = '0; ack2 = 8'(1 << c); tick(1); ack2 = '0;
        end

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
